// File: rtl/aes_key_expand_iter.sv
// Iterative AES-128/256 key expansion: accepts a key, generates WPC schedule
// words per cycle, then holds the full 60-word schedule until it is consumed.
module aes_key_expand_iter #(
  parameter int WPC        = 4,
  parameter bit ENABLE_256 = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic           i_mode,
  input  logic [0:255]   i_key,
  output logic           o_valid,
  input  logic           i_ready,
  output logic           o_mode,
  output logic [0:1919]  o_key_schedule
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] w_q [0:59];
  logic [31:0] w_d [0:59];
  logic [5:0]  p_q, p_d;
  logic        mode_q, mode_d;
  logic [31:0] grp [0:WPC-1];
  logic        accMode;
  logic        m256;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] prod;
    logic [7:0] aa;
    prod = '0;
    aa   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return prod;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign accMode = ENABLE_256 && i_mode;
  assign m256    = ENABLE_256 && mode_q;

  // Words of one group chain through prev; one S-box row per word serves both rules.
  always_comb begin : expandWords
    logic [31:0] prev;
    logic [31:0] back;
    logic [31:0] sIn;
    logic [31:0] sOut;
    logic [31:0] t;
    logic [31:0] nw;
    logic [5:0]  j;
    logic        isRcon;
    logic        isSub;
    prev = w_q[p_q - 6'd1];
    for (int g = 0; g < WPC; g++) begin
      j      = p_q + 6'(g);
      back   = m256 ? w_q[j - 6'd8] : w_q[j - 6'd4];
      isRcon = m256 ? (j[2:0] == 3'd0) : (j[1:0] == 2'd0);
      isSub  = m256 && (j[2:0] == 3'd4);
      sIn    = isRcon ? {prev[23:0], prev[31:24]} : prev;
      sOut   = subWord(sIn);
      if (isRcon)     t = sOut ^ {rcon(m256 ? {1'b0, j[5:3]} : j[5:2]), 24'h0};
      else if (isSub) t = sOut;
      else            t = prev;
      nw     = back ^ t;
      grp[g] = nw;
      prev   = nw;
    end
  end

  always_comb begin : nextState
    state_d = state_q;
    p_d     = p_q;
    mode_d  = mode_q;
    for (int k = 0; k < 60; k++) w_d[k] = w_q[k];
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = EXPAND;
          mode_d  = accMode;
          p_d     = accMode ? 6'd8 : 6'd4;
          for (int k = 0; k < 8; k++) w_d[k] = (k < 4 || accMode) ? i_key[32*k +: 32] : '0;
          for (int k = 8; k < 60; k++) w_d[k] = '0;
        end
      end
      EXPAND: begin
        for (int g = 0; g < WPC; g++) w_d[p_q + 6'(g)] = grp[g];
        p_d = p_q + 6'(WPC);
        if (p_d == (m256 ? 6'd60 : 6'd44)) state_d = DONE;
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
          p_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!ENABLE_256) for (int k = 44; k < 60; k++) w_d[k] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      mode_q  <= 1'b0;
      for (int k = 0; k < 60; k++) w_q[k] <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      mode_q  <= mode_d;
      for (int k = 0; k < 60; k++) w_q[k] <= w_d[k];
    end
  end

  assign o_ready = (state_q == IDLE) && !rst;
  assign o_valid = (state_q == DONE) && !rst;
  assign o_mode  = mode_q;

  for (genvar k = 0; k < 60; k++) begin : g_out
    assign o_key_schedule[32*k +: 32] = w_q[k];
  end

endmodule

// File: tb/tb_aes_key_expand_iter.sv
// Scoreboard bench: three engines (WPC 4, 2, 1) share stimulus and are checked
// against FIPS-197 key-expansion vectors at each output handshake.
module tb_aes_key_expand_iter;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic          clk;
  logic          rst;
  logic          iValid;
  logic          iMode;
  logic          iReady;
  logic [0:255]  iKey;
  logic          oReady [3];
  logic          oValid [3];
  logic          oMode  [3];
  logic [0:1919] sched  [3];

  int cycle = 0;
  int testsRun;
  int failCnt;
  int acceptCycle [3];
  int riseLat [3];
  bit prevValid [3];
  int expQ [3][$];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    aes_key_expand_iter #(
      .WPC(gi == 0 ? 4 : (gi == 1 ? 2 : 1)),
      .ENABLE_256(1'b1)
    ) dut (
      .clk(clk),
      .rst(rst),
      .i_valid(iValid),
      .o_ready(oReady[gi]),
      .i_mode(iMode),
      .i_key(iKey),
      .o_valid(oValid[gi]),
      .i_ready(iReady),
      .o_mode(oMode[gi]),
      .o_key_schedule(sched[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int wpcOf(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
  endfunction

  function automatic bit allReady();
    return oReady[0] && oReady[1] && oReady[2];
  endfunction

  task automatic check(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL dut%0d %s: got %h, expected %h", d, name, act, exp);
    end
  endtask

  task automatic checkZero(input int d, input string name);
    testsRun++;
    if (sched[d] !== '0) begin
      failCnt++;
      $display("[TB] FAIL dut%0d %s: %0d schedule bits set, expected 0", d, name, $countones(sched[d]));
    end
  endtask

  task automatic checkWord(input int d, input logic [0:1919] s, input int k, input logic [31:0] exp);
    logic [31:0] act;
    act = s[32*k +: 32];
    testsRun++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL dut%0d w[%0d]: got %h, expected %h", d, k, act, exp);
    end
  endtask

  task automatic checkOutput(input int d, input int vec, input logic [0:1919] s, input logic m, input int lat);
    check(d, "latency", lat, ((vec == 0) ? 40 : 52) / wpcOf(d));
    check(d, "o_mode", m, (vec == 1) ? 1 : 0);
    if (vec == 0) begin
      checkWord(d, s, 0,  32'h2b7e1516);
      checkWord(d, s, 3,  32'h09cf4f3c);
      checkWord(d, s, 4,  32'ha0fafe17);
      checkWord(d, s, 5,  32'h88542cb1);
      checkWord(d, s, 6,  32'h23a33939);
      checkWord(d, s, 7,  32'h2a6c7605);
      checkWord(d, s, 40, 32'hd014f9a8);
      checkWord(d, s, 41, 32'hc9ee2589);
      checkWord(d, s, 42, 32'he13f0cc8);
      checkWord(d, s, 43, 32'hb6630ca6);
      testsRun++;
      if (s[1408:1919] !== '0) begin
        failCnt++;
        $display("[TB] FAIL dut%0d upperZero: %0d bits set, expected 0", d, $countones(s[1408:1919]));
      end
    end else begin
      checkWord(d, s, 0,  32'h603deb10);
      checkWord(d, s, 7,  32'h0914dff4);
      checkWord(d, s, 8,  32'h9ba35411);
      checkWord(d, s, 9,  32'h8e6925af);
      checkWord(d, s, 10, 32'ha51a8b5f);
      checkWord(d, s, 11, 32'h2067fcde);
      checkWord(d, s, 12, 32'ha8b09c1a);
      checkWord(d, s, 56, 32'hfe4890d1);
      checkWord(d, s, 57, 32'he6188d0b);
      checkWord(d, s, 58, 32'h046df344);
      checkWord(d, s, 59, 32'h706c631e);
    end
  endtask

  task automatic recordAccept(input int vec);
    for (int d = 0; d < 3; d++) begin
      acceptCycle[d] = cycle;
      expQ[d].push_back(vec);
    end
  endtask

  // Presents a vector, waits for the shared accept edge, optionally scrambles the key afterwards.
  task automatic applyStimulus(input int vec, input bit changeKey);
    int guard;
    bit ok;
    guard  = 0;
    ok     = 1'b0;
    iValid = 1'b1;
    iMode  = (vec == 1);
    iKey   = (vec == 1) ? KEY256 : KEY128;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = allReady();
      guard++;
    end
    if (!ok) begin
      testsRun++;
      failCnt++;
      $display("[TB] FAIL acceptTimeout: o_ready not seen, expected 1 within 200 cycles");
      iValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    recordAccept(vec);
    iValid = 1'b0;
    if (changeKey) iKey = ~iKey;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0) begin
      testsRun++;
      failCnt++;
      $display("[TB] FAIL drainTimeout: %0d outputs outstanding, expected 0",
               expQ[0].size() + expQ[1].size() + expQ[2].size());
      for (int d = 0; d < 3; d++) expQ[d].delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    int v;
    testsRun = 0;
    failCnt  = 0;
    rst      = 1'b1;
    iValid   = 1'b0;
    iMode    = 1'b0;
    iReady   = 1'b1;
    iKey     = '0;
    for (int d = 0; d < 3; d++) begin
      prevValid[d]   = 1'b0;
      riseLat[d]     = 0;
      acceptCycle[d] = 0;
    end

    // Monitor: latency is measured on the rising o_valid, data checked at the handshake.
    fork
      forever begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
          if (oValid[d] && !prevValid[d]) riseLat[d] = cycle - acceptCycle[d];
          prevValid[d] = oValid[d];
          if (oValid[d] && iReady) begin
            if (expQ[d].size() == 0) begin
              testsRun++;
              failCnt++;
              $display("[TB] FAIL dut%0d unexpectedOutput: o_valid=1, expected no output", d);
            end else begin
              v = expQ[d].pop_front();
              checkOutput(d, v, sched[d], oMode[d], riseLat[d]);
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check(d, "resetReady", oReady[d], 0);
      check(d, "resetValid", oValid[d], 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check(d, "readyAfterReset", oReady[d], 1);
      check(d, "modeAfterReset", oMode[d], 0);
      checkZero(d, "scheduleAfterReset");
    end
    @(posedge clk);
    #1;

    applyStimulus(0, 1'b0);
    waitDrain();
    applyStimulus(1, 1'b0);
    waitDrain();

    applyStimulus(1, 1'b1);
    waitDrain();
    applyStimulus(0, 1'b1);
    waitDrain();

    // Backpressure: engines sit in DONE while a different key is being offered.
    iReady = 1'b0;
    applyStimulus(0, 1'b0);
    guard = 0;
    while (!(oValid[0] && oValid[1] && oValid[2]) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(0, "allDone", (oValid[0] && oValid[1] && oValid[2]) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    iValid = 1'b1;
    iMode  = 1'b1;
    iKey   = KEY256;
    repeat (7) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check(d, "stallReady", oReady[d], 0);
        check(d, "stallValid", oValid[d], 1);
      end
    end
    @(posedge clk);
    #1 iReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) check(d, "readyAfterHandshake", oReady[d], 1);
    @(posedge clk);
    #1;
    recordAccept(1);
    iValid = 1'b0;
    waitDrain();

    // Reset three cycles into an AES-256 expansion.
    applyStimulus(1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int d = 0; d < 3; d++) expQ[d].delete();
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check(d, "midResetValid", oValid[d], 0);
      check(d, "midResetReady", oReady[d], 0);
      check(d, "midResetMode", oMode[d], 0);
      checkZero(d, "midResetSchedule");
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check(d, "readyAfterMidReset", oReady[d], 1);
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  end

endmodule
